// File: rtl/mem_responder32.sv
// Memory-side responder for the multicycle MIPS core: word RAM, program loader
// holding the core in reset, and an optional console FIFO (MEM_RESP_MMIO_EN).
module mem_responder32 #(
  parameter int DEPTH_LOG2 = 8,
  parameter int FIFO_LOG2  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] adr,
  input  logic [31:0] writedata,
  output logic [31:0] memdata,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        cpu_reset,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        err
);

  typedef enum logic {LOAD, RUN} state_t;

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] load_ptr;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           ram [2**DEPTH_LOG2];
  logic                  run;
  logic                  load_fire;
  logic                  misaligned;
  logic                  ram_we;
  logic [31:0]           ram_word;

  assign run        = (state == RUN);
  assign idx        = adr[DEPTH_LOG2+1:2];
  assign misaligned = (adr[1:0] != 2'b00);
  assign load_fire  = load_valid & load_ready;
  assign ram_word   = ram[idx];

  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_ready = 1'b0;
    cpu_reset  = 1'b0;
    case (state)
      LOAD: begin
        load_ready = 1'b1;
        cpu_reset  = 1'b1;
        if (load_valid && load_last) state_next = RUN;
      end
      RUN: ;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)          load_ptr <= '0;
    else if (load_fire) load_ptr <= load_ptr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)                                     err <= 1'b0;
    else if (run && (memread || memwrite) && misaligned) err <= 1'b1;
  end

  // Loader and core writes are mutually exclusive by state; RAM is never cleared.
  always_ff @(posedge clk) begin
    if (load_fire)   ram[load_ptr] <= load_data;
    else if (ram_we) ram[idx]      <= writedata;
  end

`ifdef MEM_RESP_MMIO_EN
  localparam int FDEPTH = 2**FIFO_LOG2;

  logic [7:0]           fifo [FDEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_LOG2:0]   count;
  logic                 full, overflow;
  logic                 is_tx, is_stat;
  logic                 push, pop, push_ok;

  assign is_tx   = (adr == 32'hFFFF_FFF0);
  assign is_stat = (adr == 32'hFFFF_FFF4);
  assign full    = (count == (FIFO_LOG2+1)'(FDEPTH));
  assign push    = run & memwrite & is_tx;
  assign pop     = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push & (~full | pop);
  assign ram_we  = run & memwrite & ~misaligned & ~is_tx;

  assign out_valid = (count != '0);
  assign out_data  = out_valid ? fifo[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo[wr_ptr] <= writedata[7:0];
  end

  always_comb begin
    memdata = '0;
    if (run && memread) memdata = is_stat ? {30'b0, overflow, full} : ram_word;
  end
`else
  logic unused_ready;

  assign unused_ready = out_ready;
  assign ram_we       = run & memwrite & ~misaligned;
  assign out_valid    = 1'b0;
  assign out_data     = '0;

  always_comb begin
    memdata = '0;
    if (run && memread) memdata = ram_word;
  end
`endif

  logic unused_adr;
  assign unused_adr = ^adr[31:DEPTH_LOG2+2];

endmodule
